// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART rate constants and receiver state encoding
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 16;
  localparam int UART_DATA_BITS    = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_rx_state_t;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for a single asynchronous input
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver with mid-bit sampling and stop-bit checking
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 CLKIN,
  input  logic                 RESETN,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] DATA,
  output logic                 VALID,
  output logic                 FRAME_ERR,
  output logic                 BUSY
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  uart_rx_state_t       state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 rxs, rxs_prev;

  sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (CLKIN),
    .rst_n (RESETN),
    .d     (RX),
    .q     (rxs)
  );

  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shreg_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      rxs_prev <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shreg_q  <= shreg_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      rxs_prev <= rxs;
    end
  end

  // Start needs a falling edge, so a line stuck low never re-arms the receiver.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rxs_prev && !rxs) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rxs ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_FULL) begin
          shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
          cnt_d   = '0;
          idx_d   = idx_q + IW'(1);
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (rxs) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign DATA      = data_q;
  assign VALID     = valid_q;
  assign FRAME_ERR = ferr_q;
  assign BUSY      = (state_q != ST_IDLE);

endmodule
